// File: rtl/div_unit.sv
// div_unit: iterative 32-bit RISC-V M-extension divider (DIV/DIVU/REM/REMU).
// It uses restoring division, one quotient bit per cycle. A result register
// feeds the register-file write port.
module div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  funct3,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic [4:0]  rd_in,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic        wb_enable,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 6;
    localparam int unsigned RD_W  = 5;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [XLEN-1:0]  quo;
    logic [XLEN-1:0]  rem;
    logic [XLEN-1:0]  dvs;
    logic [CNT_W-1:0] cnt;
    logic             neg_q;
    logic             neg_r;
    logic             sel_rem;
    logic [RD_W-1:0]  rd_q;

    logic             accept_c;
    logic             is_signed_c;
    logic             a_neg_c;
    logic             b_neg_c;
    logic [XLEN-1:0]  a_mag_c;
    logic [XLEN-1:0]  b_mag_c;
    logic             div_zero_c;
    logic             ovf_c;
    logic [XLEN:0]    rem_sh_c;
    logic [XLEN:0]    diff_c;
    logic [XLEN-1:0]  res_q_c;
    logic [XLEN-1:0]  res_r_c;

    // Operand decode: acceptance, signs, magnitudes and special cases
    always_comb begin
        accept_c    = (state == S_IDLE) && start && funct3[2] && !flush;
        is_signed_c = ~funct3[0];
        a_neg_c     = is_signed_c & rs1_data[XLEN-1];
        b_neg_c     = is_signed_c & rs2_data[XLEN-1];
        a_mag_c     = a_neg_c ? (XLEN'(0) - rs1_data) : rs1_data;
        b_mag_c     = b_neg_c ? (XLEN'(0) - rs2_data) : rs2_data;
        div_zero_c  = (rs2_data == '0);
        ovf_c       = is_signed_c && (rs1_data == 32'h8000_0000) && (rs2_data == '1);
    end

    // One restoring step plus sign correction of the final result
    always_comb begin
        rem_sh_c = {rem, quo[XLEN-1]};
        diff_c   = rem_sh_c - {1'b0, dvs};
        res_q_c  = neg_q ? (XLEN'(0) - quo) : quo;
        res_r_c  = neg_r ? (XLEN'(0) - rem) : rem;
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    // Next-state logic; special cases skip CALC entirely
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (accept_c) state_nxt = (div_zero_c || ovf_c) ? S_FIN : S_CALC;
            S_CALC: begin
                if (flush)                               state_nxt = S_IDLE;
                else if (cnt == CNT_W'(XLEN - 1))        state_nxt = S_FIN;
            end
            S_FIN:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Operand capture and iterative quotient/remainder datapath
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            quo     <= '0;
            rem     <= '0;
            dvs     <= '0;
            cnt     <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            sel_rem <= 1'b0;
            rd_q    <= '0;
        end else if (accept_c) begin
            sel_rem <= funct3[1];
            rd_q    <= rd_in;
            cnt     <= '0;
            dvs     <= b_mag_c;
            if (div_zero_c) begin
                quo   <= '1;
                rem   <= rs1_data;
                neg_q <= 1'b0;
                neg_r <= 1'b0;
            end else if (ovf_c) begin
                quo   <= 32'h8000_0000;
                rem   <= '0;
                neg_q <= 1'b0;
                neg_r <= 1'b0;
            end else begin
                quo   <= a_mag_c;
                rem   <= '0;
                neg_q <= a_neg_c ^ b_neg_c;
                neg_r <= a_neg_c;
            end
        end else if (state == S_CALC) begin
            quo <= {quo[XLEN-2:0], ~diff_c[XLEN]};
            rem <= diff_c[XLEN] ? rem_sh_c[XLEN-1:0] : diff_c[XLEN-1:0];
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Registered status and write-back port; FIN presents the result
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            wb_enable <= 1'b0;
            wb_rd     <= '0;
            wb_data   <= '0;
        end else begin
            busy      <= (state_nxt != S_IDLE);
            done      <= 1'b0;
            wb_enable <= 1'b0;
            if ((state == S_FIN) && !flush) begin
                done      <= 1'b1;
                wb_enable <= (rd_q != '0);
                wb_rd     <= rd_q;
                wb_data   <= sel_rem ? res_r_c : res_q_c;
            end
        end
    end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 Parameters: none; datapath width SHALL be fixed at 32 bits.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request a divide; sampled only in IDLE.
REQ-005 funct3  input  3  100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 rs1_data  input  32  dividend, from register-file read port 1.
REQ-007 rs2_data  input  32  divisor, from register-file read port 2.
REQ-008 rd_in  input  5  destination register index.
REQ-009 flush  input  1  synchronous abort of an in-flight operation.
REQ-010 busy  output  1  high in CALC and FIN.
REQ-011 done  output  1  one-cycle pulse when a result is presented.
REQ-012 wb_enable  output  1  register-file write enable; high only with done and wb_rd != 0.
REQ-013 wb_rd  output  5  register-file write index.
REQ-014 wb_data  output  32  result to be written.

Function
REQ-015 The block SHALL have a three-state FSM: IDLE, CALC, FIN.
REQ-016 In IDLE, start=1 with funct3[2]=1 SHALL capture operands, funct3 and rd_in in the same edge; start with funct3[2]=0 SHALL be ignored.
REQ-017 Special cases SHALL go IDLE->FIN directly, with done at the cycle after start.
  - Divisor 0: quotient 0xFFFFFFFF, remainder = dividend.
  - Signed DIV/REM with 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0.
REQ-018 Otherwise IDLE->CALC.
  - Signed ops SHALL divide magnitudes and record result signs: quotient sign = XOR of operand signs; remainder sign = dividend sign.
REQ-019 CALC SHALL perform one restoring-division step per cycle using a 6-bit counter, for exactly 32 cycles, then enter FIN.
REQ-020 Normal-path latency: start sampled at edge T SHALL give done=1 during cycle T+33, for the cycle following edge T+33.
REQ-021 FIN SHALL last exactly one cycle, drive done=1 with wb_data and wb_rd valid, then return to IDLE.
REQ-022 wb_data selection: quotient for DIV/DIVU, remainder for REM/REMU, with sign correction applied.
REQ-023 wb_enable SHALL equal done AND (wb_rd != 0); done SHALL still pulse when wb_rd = 0.
REQ-024 start while busy=1 SHALL be ignored; captured operands SHALL not change.
REQ-025 A new start SHALL be accepted in the cycle immediately after FIN (back-to-back).
REQ-026 flush=1 in CALC or FIN SHALL return to IDLE at the next edge with done=0 and wb_enable=0.
REQ-027 flush=1 in IDLE SHALL block acceptance of a simultaneous start.
REQ-028 done, wb_enable, wb_rd and wb_data SHALL be registered outputs.
REQ-029 Outside FIN, done and wb_enable SHALL be 0, and wb_data and wb_rd SHALL hold their last value.

Reset
REQ-030 rst=0 SHALL immediately, independent of clk:
  - force IDLE;
  - clear counter and operand registers;
  - drive busy=0, done=0, wb_enable=0, wb_rd=0, wb_data=0.
REQ-031 Reset asserted mid-CALC SHALL discard the operation; no done SHALL follow reset release.
REQ-032 After rst returns high, the first start SHALL be accepted at the next rising edge.

Verification
REQ-033 DIVU 100/7, rd=5 -> done at start+33 cycles; wb_data=14, wb_rd=5, wb_enable=1; busy high 33 cycles.
REQ-034 DIV -20/3 -> wb_data=0xFFFFFFFA (-6); REM -20/3 -> wb_data=0xFFFFFFFE (-2).
REQ-035 Special cases, each with done one cycle after start:
  - DIV 7/0 -> wb_data=0xFFFFFFFF.
  - REMU 7/0 -> wb_data=7.
  - DIV 0x80000000/0xFFFFFFFF -> wb_data=0x80000000.
  - REM 0x80000000/0xFFFFFFFF -> wb_data=0.
REQ-036 DIVU 9/2 with rd=0 -> done pulses, wb_enable stays 0.
REQ-037 Second start pulsed at cycle 10 of a busy operation -> ignored; first result is unchanged.
REQ-038 Interrupt tests:
  - flush at cycle 20 of CALC -> IDLE, no done.
  - rst=0 at cycle 15 -> all outputs 0 asynchronously; a new DIVU 50/5 afterwards -> wb_data=10.
